video_mode_sequencer: RTL and testbench

- Sequences every video-mode bring-up and mode change in the lag tester.
- On power-up or a resolution-config change it does the following in order:
  - blanks the video generator;
  - reprograms the video PLL;
  - waits for PLL lock and a settle interval;
  - re-initialises the DVI transmitter over its I2C init engine;
  - clears measurement statistics;
  - re-enables video.
- Sits in the base clock domain, between the configuration block, the PLL reconfig port, the TFP410 init engine, the measurement block and the video generator.

---
 rtl/video_mode_sequencer_pkg.sv | 29 ++
 rtl/video_mode_sequencer_timer.sv | 30 +++
 rtl/video_mode_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_video_mode_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_mode_sequencer_pkg.sv
// Shared types and default constants for the video mode bring-up sequencer.
package video_mode_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_BLANK     = 3'd0,
    ST_RECONF    = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_HOLD      = 3'd4,
    ST_TFP_INIT  = 3'd5,
    ST_RUN       = 3'd6,
    ST_ERROR     = 3'd7
  } state_t;

  localparam int unsigned DEF_LOCK_TIMEOUT  = 32'd1048576;
  localparam int unsigned DEF_SETTLE_CYCLES = 32'd4096;
  localparam int unsigned DEF_TFP_TIMEOUT   = 32'd4194304;
  localparam int unsigned DEF_MAX_RETRIES   = 32'd3;

  // Cycles the PLL reconfig engine gets to raise busy before we assume it finished.
  localparam int unsigned RECONF_GRACE      = 32'd16;

  localparam int RETRY_W = 2;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/video_mode_sequencer_timer.sv
// Saturating cycle counter shared by every timed state of the sequencer.
module seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // Count up while enabled, stick at all-ones, clear on request.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = (r_count >= i_limit);

endmodule

// File: rtl/video_mode_sequencer.sv
// Video mode bring-up sequencer: blank, reprogram PLL, wait lock+settle,
// re-init the DVI transmitter, clear measurements, re-enable video.
module video_mode_sequencer
  import video_mode_sequencer_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned TFP_TIMEOUT   = DEF_TFP_TIMEOUT,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               config_changed,
  input  logic [7:0]         config_data,
  output logic               pll_reconfig_start,
  output logic [7:0]         pll_reconfig_data,
  input  logic               pll_reconfig_busy,
  input  logic               pll_locked,
  output logic               tfp_init_start,
  input  logic               tfp_ready,
  input  logic               hpd_detected,
  output logic               video_enable,
  output logic               measure_reset,
  output logic               busy,
  output logic               error,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int unsigned TMR_MAX =
    max2(max2(LOCK_TIMEOUT, TFP_TIMEOUT), max2(SETTLE_CYCLES, RECONF_GRACE));
  localparam int TW = $clog2(TMR_MAX + 1);

  state_t             r_state;
  logic               r_lock_meta;
  logic               r_lock_sync;
  logic               r_tmr_clear;
  logic               r_busy_seen;
  logic               r_pending;
  logic [RETRY_W-1:0] r_retry;
  logic [7:0]         r_pll_data;
  logic               r_pll_start;
  logic               r_tfp_start;
  logic               r_meas_rst;
  logic               r_video_enable;
  logic               r_busy;
  logic               r_error;

  logic [TW-1:0]      w_tmr_limit;
  logic               w_tmr_done;
  logic               w_tmr_hit;
  logic               w_tmr_enable;
  logic [RETRY_W-1:0] w_retry_inc;
  logic               w_retry_exhausted;
  logic               w_reconf_done;

  // Two-flop synchroniser for the asynchronous PLL lock indicator.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_sync <= r_lock_meta;
    end
  end

  // Select the terminal count for whichever state owns the shared timer.
  always_comb begin
    w_tmr_limit = '0;
    case (r_state)
      ST_RECONF:    w_tmr_limit = TW'(RECONF_GRACE);
      ST_WAIT_LOCK: w_tmr_limit = TW'(LOCK_TIMEOUT);
      ST_SETTLE:    w_tmr_limit = TW'(SETTLE_CYCLES);
      ST_TFP_INIT:  w_tmr_limit = TW'(TFP_TIMEOUT);
      default:      w_tmr_limit = '0;
    endcase
  end

  // The first cycle after a state entry is spent clearing the timer, so its
  // terminal flag still reflects the previous state and must be ignored.
  assign w_tmr_enable      = ~r_tmr_clear;
  assign w_tmr_hit         = w_tmr_done & ~r_tmr_clear;
  assign w_retry_inc       = r_retry + 2'd1;
  assign w_retry_exhausted = ({30'd0, w_retry_inc} >= MAX_RETRIES);
  assign w_reconf_done     = ~pll_reconfig_busy & (r_busy_seen | w_tmr_hit);

  seq_timer #(
    .WIDTH(TW)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (r_tmr_clear),
    .i_enable (w_tmr_enable),
    .i_limit  (w_tmr_limit),
    .o_done   (w_tmr_done)
  );

  // Enter a state: restart the timer and set the level outputs it implies.
  task automatic go_to(input state_t s);
    r_state        <= s;
    r_tmr_clear    <= 1'b1;
    r_video_enable <= (s == ST_RUN);
    r_busy         <= (s != ST_RUN);
    r_error        <= (s == ST_ERROR);
  endtask

  // Record a failed attempt and either retry from BLANK or give up.
  task automatic fail_attempt();
    r_retry <= w_retry_inc;
    if (w_retry_exhausted) begin
      go_to(ST_ERROR);
    end else begin
      go_to(ST_BLANK);
    end
  endtask

  // Sequencer state machine with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_BLANK;
      r_tmr_clear    <= 1'b1;
      r_busy_seen    <= 1'b0;
      r_pending      <= 1'b0;
      r_retry        <= '0;
      r_pll_data     <= 8'h00;
      r_pll_start    <= 1'b0;
      r_tfp_start    <= 1'b0;
      r_meas_rst     <= 1'b0;
      r_video_enable <= 1'b0;
      r_busy         <= 1'b1;
      r_error        <= 1'b0;
    end else begin
      r_pll_start <= 1'b0;
      r_tfp_start <= 1'b0;
      r_meas_rst  <= 1'b0;
      r_tmr_clear <= 1'b0;
      if (config_changed && (r_state != ST_RECONF)) begin
        // A new mode overrides whatever else happens this cycle.
        r_retry   <= '0;
        r_pending <= 1'b0;
        go_to(ST_BLANK);
      end else begin
        case (r_state)
          ST_BLANK: begin
            if (!pll_reconfig_busy) begin
              r_pll_data  <= config_data;
              r_pll_start <= 1'b1;
              r_busy_seen <= 1'b0;
              go_to(ST_RECONF);
            end
          end
          ST_RECONF: begin
            if (config_changed) begin
              r_pending <= 1'b1;
            end
            if (pll_reconfig_busy) begin
              r_busy_seen <= 1'b1;
            end
            if (w_reconf_done) begin
              if (r_pending || config_changed) begin
                r_pending <= 1'b0;
                r_retry   <= '0;
                go_to(ST_BLANK);
              end else begin
                go_to(ST_WAIT_LOCK);
              end
            end
          end
          ST_WAIT_LOCK: begin
            if (r_lock_sync) begin
              go_to(ST_SETTLE);
            end else if (w_tmr_hit) begin
              fail_attempt();
            end
          end
          ST_SETTLE: begin
            if (!r_lock_sync) begin
              // Keep the running count so lock flapping cannot extend the timeout.
              r_state <= ST_WAIT_LOCK;
            end else if (w_tmr_hit) begin
              if (hpd_detected) begin
                r_tfp_start <= 1'b1;
                go_to(ST_TFP_INIT);
              end else begin
                go_to(ST_HOLD);
              end
            end
          end
          ST_HOLD: begin
            if (!r_lock_sync) begin
              go_to(ST_BLANK);
            end else if (hpd_detected) begin
              r_tfp_start <= 1'b1;
              go_to(ST_TFP_INIT);
            end
          end
          ST_TFP_INIT: begin
            // tfp_ready may still be high from a previous init on the entry cycle.
            if (tfp_ready && !r_tmr_clear) begin
              r_meas_rst <= 1'b1;
              r_retry    <= '0;
              go_to(ST_RUN);
            end else if (w_tmr_hit) begin
              fail_attempt();
            end
          end
          ST_RUN: begin
            if (!r_lock_sync) begin
              go_to(ST_BLANK);
            end else if (!hpd_detected) begin
              go_to(ST_HOLD);
            end
          end
          ST_ERROR: begin
            r_state <= ST_ERROR;
          end
          default: begin
            go_to(ST_BLANK);
          end
        endcase
      end
    end
  end

  assign pll_reconfig_start = r_pll_start;
  assign pll_reconfig_data  = r_pll_data;
  assign tfp_init_start     = r_tfp_start;
  assign measure_reset      = r_meas_rst;
  assign video_enable       = r_video_enable;
  assign busy               = r_busy;
  assign error              = r_error;
  assign retry_count        = r_retry;

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Directed bench for video_mode_sequencer with simple PLL/TFP responders.
module tb_video_mode_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       config_changed;
  logic [7:0] config_data;
  logic       pll_reconfig_start;
  logic [7:0] pll_reconfig_data;
  logic       pll_reconfig_busy;
  logic       pll_locked;
  logic       tfp_init_start;
  logic       tfp_ready;
  logic       hpd_detected;
  logic       video_enable;
  logic       measure_reset;
  logic       busy;
  logic       error;
  logic [1:0] retry_count;

  int n_checks = 0;
  int n_errors = 0;

  // responder state
  int cyc = 0;
  int busy_len = 10;
  int busy_left = 0;
  int lock_delay = 50;
  int lock_left = 0;
  bit lock_en = 1'b1;
  int tfp_delay = 200;
  int tfp_left = 0;
  int n_pll = 0;
  int n_tfp = 0;
  int n_meas = 0;
  int n_wide = 0;
  logic [7:0] last_data = 8'h00;
  int busy_fall_cyc = 0;
  int last_start_cyc = 0;
  int last_tfp_cyc = 0;
  bit prev_pll = 1'b0;
  bit prev_tfp = 1'b0;
  bit prev_meas = 1'b0;

  video_mode_sequencer #(
    .LOCK_TIMEOUT (100),
    .SETTLE_CYCLES(64),
    .TFP_TIMEOUT  (1000),
    .MAX_RETRIES  (3)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .config_changed    (config_changed),
    .config_data       (config_data),
    .pll_reconfig_start(pll_reconfig_start),
    .pll_reconfig_data (pll_reconfig_data),
    .pll_reconfig_busy (pll_reconfig_busy),
    .pll_locked        (pll_locked),
    .tfp_init_start    (tfp_init_start),
    .tfp_ready         (tfp_ready),
    .hpd_detected      (hpd_detected),
    .video_enable      (video_enable),
    .measure_reset     (measure_reset),
    .busy              (busy),
    .error             (error),
    .retry_count       (retry_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic pulse_cfg(input logic [7:0] d);
    config_data    = d;
    config_changed = 1'b1;
    tick();
    config_changed = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int budget);
    int n = 0;
    while (!(video_enable && !busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_run"}, 32'(video_enable && !busy), 32'd1);
  endtask

  task automatic wait_retry(input logic [1:0] v, input int budget);
    int n = 0;
    while (retry_count != v && n < budget) begin
      tick();
      n++;
    end
    check("retry_step", 32'(retry_count), 32'(v));
  endtask

  // PLL and TFP410 behavioural responders, acting on the falling edge.
  initial begin
    pll_reconfig_busy = 1'b0;
    pll_locked        = 1'b0;
    tfp_ready         = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (lock_left > 0) begin
        lock_left--;
        if (lock_left == 0) pll_locked = 1'b1;
      end
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          pll_reconfig_busy = 1'b0;
          busy_fall_cyc = cyc;
          if (lock_en) lock_left = lock_delay;
        end
      end
      if (tfp_left > 0) begin
        tfp_left--;
        if (tfp_left == 0) tfp_ready = 1'b1;
      end
      if (pll_reconfig_start && prev_pll) n_wide++;
      if (tfp_init_start && prev_tfp) n_wide++;
      if (measure_reset && prev_meas) n_wide++;
      prev_pll  = pll_reconfig_start;
      prev_tfp  = tfp_init_start;
      prev_meas = measure_reset;
      if (pll_reconfig_start) begin
        n_pll++;
        last_data         = pll_reconfig_data;
        last_start_cyc    = cyc;
        pll_locked        = 1'b0;
        lock_left         = 0;
        pll_reconfig_busy = 1'b1;
        busy_left         = busy_len;
      end
      if (tfp_init_start) begin
        n_tfp++;
        last_tfp_cyc = cyc;
        tfp_ready    = 1'b0;
        tfp_left     = tfp_delay;
      end
      if (measure_reset) n_meas++;
    end
  end

  initial begin
    int base_pll;
    int base_tfp;
    int glitch_end;
    int n;
    bit ve_seen;

    reset          = 1'b1;
    config_changed = 1'b0;
    config_data    = 8'h03;
    hpd_detected   = 1'b1;
    repeat (3) tick();

    // reset values
    check("rst_video_enable", 32'(video_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    check("rst_retry", 32'(retry_count), 32'd0);
    check("rst_pll_data", 32'(pll_reconfig_data), 32'h00);
    check("rst_pulses", 32'({pll_reconfig_start, tfp_init_start, measure_reset}), 32'd0);

    // power-up bring-up without config_changed
    reset = 1'b0;
    wait_run("boot", 2000);
    check("boot_pll_starts", n_pll, 32'd1);
    check("boot_pll_data", 32'(last_data), 32'h03);
    check("boot_tfp_starts", n_tfp, 32'd1);
    check("boot_meas", n_meas, 32'd1);
    check("boot_error", 32'(error), 32'd0);

    // mode change from RUN
    pulse_cfg(8'h05);
    check("cfg_video_off", 32'(video_enable), 32'd0);
    check("cfg_busy", 32'(busy), 32'd1);
    wait_run("cfg", 2000);
    check("cfg_pll_starts", n_pll, 32'd2);
    check("cfg_pll_data", 32'(pll_reconfig_data), 32'h05);
    check("cfg_tfp_starts", n_tfp, 32'd2);
    check("cfg_meas", n_meas, 32'd2);

    // hot-plug gap: re-init TFP only
    base_pll = n_pll;
    base_tfp = n_tfp;
    hpd_detected = 1'b0;
    ve_seen = 1'b0;
    repeat (500) begin
      tick();
      if (video_enable) ve_seen = 1'b1;
    end
    check("hpd_gap_video", 32'(ve_seen), 32'd0);
    check("hpd_gap_busy", 32'(busy), 32'd1);
    check("hpd_gap_tfp", n_tfp, base_tfp);
    hpd_detected = 1'b1;
    wait_run("hpd", 1000);
    check("hpd_no_pll", n_pll, base_pll);
    check("hpd_one_tfp", n_tfp, base_tfp + 1);

    // config_changed while the PLL engine is busy
    base_pll = n_pll;
    busy_len = 40;
    pulse_cfg(8'h07);
    repeat (10) tick();
    busy_len = 10;
    pulse_cfg(8'h09);
    n = 0;
    while (pll_reconfig_busy && n < 100) begin
      tick();
      n++;
    end
    check("pend_busy_fell", 32'(pll_reconfig_busy), 32'd0);
    check("pend_no_early_start", n_pll, base_pll + 1);
    check("pend_first_data", 32'(last_data), 32'h07);
    tick();
    tick();
    check("pend_restart", n_pll, base_pll + 2);
    check("pend_new_data", 32'(last_data), 32'h09);
    check("pend_restart_gap", last_start_cyc - busy_fall_cyc, 32'd2);
    wait_run("pend", 2000);

    // lock glitch during SETTLE
    pulse_cfg(8'h0B);
    n = 0;
    while (!pll_locked && n < 200) begin
      tick();
      n++;
    end
    check("glitch_lock_up", 32'(pll_locked), 32'd1);
    repeat (20) tick();
    base_tfp = n_tfp;
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    glitch_end = cyc;
    n = 0;
    while (n_tfp == base_tfp && n < 1000) begin
      tick();
      n++;
    end
    check("glitch_tfp_start", n_tfp, base_tfp + 1);
    check("glitch_settle_restart",
          32'((last_tfp_cyc - glitch_end >= 64) && (last_tfp_cyc - glitch_end <= 80)), 32'd1);
    wait_run("glitch", 1000);

    // lock never arrives: three attempts then ERROR
    lock_en = 1'b0;
    base_pll = n_pll;
    pulse_cfg(8'h0C);
    wait_retry(2'd1, 500);
    check("nolock_attempt1", n_pll, base_pll + 1);
    wait_retry(2'd2, 500);
    check("nolock_attempt2", n_pll, base_pll + 2);
    n = 0;
    while (!error && n < 500) begin
      tick();
      n++;
    end
    check("nolock_error", 32'(error), 32'd1);
    check("nolock_attempts", n_pll, base_pll + 3);
    check("nolock_retry", 32'(retry_count), 32'd3);
    repeat (20) tick();
    check("nolock_stays", n_pll, base_pll + 3);
    check("nolock_video", 32'(video_enable), 32'd0);
    lock_en = 1'b1;
    pulse_cfg(8'h0A);
    check("recover_error_clr", 32'(error), 32'd0);
    check("recover_retry_clr", 32'(retry_count), 32'd0);
    wait_run("recover", 2000);
    check("recover_data", 32'(pll_reconfig_data), 32'h0A);

    // reset mid-sequence
    pulse_cfg(8'h0D);
    repeat (30) tick();
    reset = 1'b1;
    tick();
    check("midrst_video", 32'(video_enable), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_pll_data", 32'(pll_reconfig_data), 32'h00);
    check("midrst_retry", 32'(retry_count), 32'd0);
    reset = 1'b0;
    wait_run("midrst", 2000);
    check("midrst_new_data", 32'(pll_reconfig_data), 32'h0D);

    check("pulse_width", n_wide, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
